// File: rtl/dcfeb_frame_aligner_if.sv
// Purpose: word bus from the GTX receiver into the frame aligner, plus the per-frame results it produces.
// Latency: none (wiring only).
// Backpressure: none; the fiber is a free-running 160 MHz stream with no ready path.
// Ports: master = GTX/receiver side (drives rx_*, force_error, err_clr); slave = aligner (drives frame outputs).
interface dcfeb_frame_aligner_if;
    logic        rx_sync_done;
    logic [15:0] rx_data;
    logic [1:0]  rx_charisk;
    logic [1:0]  rx_disperr;
    logic [1:0]  rx_notintable;
    logic        force_error;
    logic        err_clr;

    logic [3:0]  cew;
    logic [47:0] rcv_data;
    logic [15:0] rcv_kchar;
    logic [47:0] prompt_data;
    logic [2:0]  nonzero_word;
    logic        ltncy_trig;
    logic        valid;
    logic        link_good;
    logic        link_bad;
    logic        link_had_err;
    logic [15:0] errcount;

    modport master (
        output rx_sync_done, rx_data, rx_charisk, rx_disperr, rx_notintable,
        output force_error, err_clr,
        input  cew, rcv_data, rcv_kchar, prompt_data, nonzero_word,
        input  ltncy_trig, valid, link_good, link_bad, link_had_err, errcount
    );

    modport slave (
        input  rx_sync_done, rx_data, rx_charisk, rx_disperr, rx_notintable,
        input  force_error, err_clr,
        output cew, rcv_data, rcv_kchar, prompt_data, nonzero_word,
        output ltncy_trig, valid, link_good, link_bad, link_had_err, errcount
    );
endinterface

// File: rtl/dcfeb_frame_aligner.sv
// Purpose: locks onto the 4-word DCFEB frame (comma in word0) and publishes each complete frame plus link status.
// Latency: rcv_data/rcv_kchar/valid/ltncy_trig update one edge after word3 is sampled, together with cew[3].
// Backpressure: none; every 160 MHz word is consumed, downstream captures rcv_data on cew[0].
// Ports: rx_clk160, gtx_rx_reset (async, active-high), fib = word bus in / frame results out (slave modport).
module dcfeb_frame_aligner #(
    parameter int unsigned LOCK_FRAMES   = 8,
    parameter int unsigned UNLOCK_FRAMES = 4,
    parameter logic [7:0]  COMMA         = 8'hBC,
    parameter logic [7:0]  LTRIG         = 8'hFC,
    parameter logic [15:0] ERR_SAT       = 16'hFFFF   // errcount ceiling
) (
    input  logic                   rx_clk160,
    input  logic                   gtx_rx_reset,
    dcfeb_frame_aligner_if.slave   fib
);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    localparam int RUN_W = $clog2(LOCK_FRAMES + 1);
    localparam int BAD_W = $clog2(UNLOCK_FRAMES + 1);

    state_t           state_q, state_d;
    logic [1:0]       wcnt_q;          // index the next sampled word will get
    logic [1:0]       idx;             // index of the word sampled on this edge
    logic [15:0]      w0_q;
    logic             frame_bad_acc_q; // bad evidence gathered from words 0..idx-1
    logic [RUN_W-1:0] good_run_q;
    logic [BAD_W-1:0] bad_run_q;

    logic is_comma, is_bad, active, last_word, frame_end, frame_bad, lock_lost;

    always_comb begin
        is_comma  = (fib.rx_charisk == 2'b01) &&
                    ((fib.rx_data[7:0] == COMMA) || (fib.rx_data[7:0] == LTRIG));
        is_bad    = |{fib.rx_disperr, fib.rx_notintable};
        // Only HUNT may realign; once framing is assumed the counter free-runs.
        idx       = ((state_q == HUNT) && is_comma) ? 2'd0 : wcnt_q;
        active    = (state_q != HUNT);
        last_word = active && (idx == 2'd3);
        frame_end = last_word && fib.rx_sync_done;
        // At word3 a comma means the framing slipped, so it counts against the frame.
        frame_bad = frame_bad_acc_q | is_bad | fib.force_error | is_comma;
        lock_lost = (state_q == LOCKED) && frame_end && frame_bad &&
                    (bad_run_q == BAD_W'(UNLOCK_FRAMES - 1));
    end

    // FSM: state register
    always_ff @(posedge rx_clk160 or posedge gtx_rx_reset) begin
        if (gtx_rx_reset) state_q <= HUNT;
        else              state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!fib.rx_sync_done) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT:   if (is_comma) state_d = VERIFY;
                VERIFY: if (frame_end) begin
                            if (frame_bad)
                                state_d = HUNT;
                            else if (good_run_q == RUN_W'(LOCK_FRAMES - 1))
                                state_d = LOCKED;
                        end
                LOCKED: if (lock_lost) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // FSM: outputs. cew marks the word captured on the previous edge (wcnt_q - 1).
    always_comb begin
        fib.cew       = 4'b0000;
        fib.link_good = 1'b0;
        if (state_q != HUNT)   fib.cew       = 4'b0001 << (wcnt_q - 2'd1);
        if (state_q == LOCKED) fib.link_good = 1'b1;
    end

    always_ff @(posedge rx_clk160 or posedge gtx_rx_reset) begin
        if (gtx_rx_reset) begin
            wcnt_q           <= 2'd0;
            w0_q             <= 16'h0;
            frame_bad_acc_q  <= 1'b0;
            good_run_q       <= '0;
            bad_run_q        <= '0;
            fib.rcv_data     <= 48'h0;
            fib.rcv_kchar    <= 16'h0;
            fib.prompt_data  <= 48'h0;
            fib.nonzero_word <= 3'b000;
            fib.ltncy_trig   <= 1'b0;
            fib.valid        <= 1'b0;
            fib.link_bad     <= 1'b0;
            fib.link_had_err <= 1'b0;
            fib.errcount     <= 16'h0;
        end else begin
            wcnt_q <= idx + 2'd1;

            if (idx == 2'd0) begin
                w0_q            <= fib.rx_data;
                frame_bad_acc_q <= is_bad | fib.force_error | ~is_comma;
            end else begin
                frame_bad_acc_q <= frame_bad_acc_q | is_bad | fib.force_error | is_comma;
            end

            if (active) begin
                case (idx)
                    2'd1:    fib.prompt_data[15:0]  <= fib.rx_data;
                    2'd2:    fib.prompt_data[31:16] <= fib.rx_data;
                    2'd3:    fib.prompt_data[47:32] <= fib.rx_data;
                    default: ;
                endcase
            end

            fib.ltncy_trig <= 1'b0;
            if (last_word) begin
                fib.rcv_data     <= {fib.rx_data, fib.prompt_data[31:0]};
                fib.rcv_kchar    <= w0_q;
                fib.nonzero_word <= {fib.rx_data != 16'h0,
                                     fib.prompt_data[31:16] != 16'h0,
                                     fib.prompt_data[15:0] != 16'h0};
                fib.ltncy_trig   <= (w0_q[7:0] == LTRIG);
                fib.valid        <= (state_q == LOCKED) && !frame_bad;
            end
            if (state_d == HUNT) fib.valid <= 1'b0;

            if (state_q == HUNT)
                good_run_q <= '0;
            else if ((state_q == VERIFY) && frame_end && !frame_bad)
                good_run_q <= good_run_q + 1'b1;

            if (state_q != LOCKED)
                bad_run_q <= '0;
            else if (frame_end)
                bad_run_q <= frame_bad ? bad_run_q + 1'b1 : '0;

            // A clear coinciding with a bad frame wins.
            if (fib.err_clr) begin
                fib.errcount     <= 16'h0;
                fib.link_had_err <= 1'b0;
                fib.link_bad     <= 1'b0;
            end else if ((state_q == LOCKED) && frame_end && frame_bad) begin
                if (fib.errcount != ERR_SAT) fib.errcount <= fib.errcount + 16'd1;
                fib.link_had_err <= 1'b1;
                if (lock_lost) fib.link_bad <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcfeb_frame_aligner.sv
// Purpose: randomized and directed stimulus for dcfeb_frame_aligner, checked every cycle against a frame-level model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none; one word per cycle.
module tb_dcfeb_frame_aligner;
    localparam logic [15:0] ERR_SAT     = 16'd10;   // low ceiling so saturation is reachable
    localparam int          LOCK_FRAMES = 8;
    localparam int          UNLOCK      = 4;
    localparam int          S_HUNT = 0, S_VERIFY = 1, S_LOCKED = 2;

    logic rx_clk160 = 1'b0;
    logic gtx_rx_reset;
    always #5 rx_clk160 = ~rx_clk160;

    dcfeb_frame_aligner_if fib();

    dcfeb_frame_aligner #(.ERR_SAT(ERR_SAT)) dut (
        .rx_clk160    (rx_clk160),
        .gtx_rx_reset (gtx_rx_reset),
        .fib          (fib)
    );

    typedef struct {
        logic [3:0][15:0] w;
        bit k0;
        int bad_at, fe_at, clr_at, nosync_at, kc_at;
        bit bad_nt;
    } frame_t;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int          m_state, m_pos, good_run, bad_run;
    logic [15:0] fw [4];
    bit          fbad;
    logic [3:0]  e_cew;
    logic [47:0] e_rcv, e_prompt;
    logic [15:0] e_kchar, e_err;
    logic [2:0]  e_nz;
    bit          e_trig, e_valid, e_had, e_lost;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_HUNT; m_pos = -1; good_run = 0; bad_run = 0; fbad = 0;
        for (int i = 0; i < 4; i++) fw[i] = 16'h0;
        e_cew = 0; e_rcv = 0; e_prompt = 0; e_kchar = 0; e_err = 0; e_nz = 0;
        e_trig = 0; e_valid = 0; e_had = 0; e_lost = 0;
    endtask

    task automatic model_edge(input logic [15:0] d, input logic [1:0] ck, de, nt,
                              input bit fe, clr, sync);
        bit comma, bad, was_active, ev_err, ev_lost;
        comma      = (ck == 2'b01) && (d[7:0] == 8'hBC || d[7:0] == 8'hFC);
        bad        = (de != 2'b00) || (nt != 2'b00);
        was_active = (m_state != S_HUNT);
        ev_err = 0; ev_lost = 0; e_trig = 0;

        if (was_active) m_pos = (m_pos + 1) % 4;
        else            m_pos = comma ? 0 : -1;

        if (m_pos == 0) begin
            fw[0] = d;
            fbad  = bad || fe || !comma;
        end else if (m_pos > 0) begin
            fw[m_pos] = d;
            fbad = fbad || bad || fe || comma;
            e_prompt[16*(m_pos-1) +: 16] = d;
        end

        if (was_active && m_pos == 3) begin
            e_rcv   = {fw[3], fw[2], fw[1]};
            e_kchar = fw[0];
            e_nz    = {fw[3] != 0, fw[2] != 0, fw[1] != 0};
            e_trig  = (fw[0][7:0] == 8'hFC);
            e_valid = (m_state == S_LOCKED) && !fbad;
        end

        if (!sync) m_state = S_HUNT;
        else if (m_state == S_HUNT) begin
            if (comma) begin m_state = S_VERIFY; good_run = 0; end
        end else if (m_pos == 3) begin
            if (m_state == S_VERIFY) begin
                if (fbad) m_state = S_HUNT;
                else begin
                    good_run++;
                    if (good_run == LOCK_FRAMES) begin m_state = S_LOCKED; bad_run = 0; end
                end
            end else begin
                if (fbad) begin
                    ev_err = 1;
                    bad_run++;
                    if (bad_run == UNLOCK) begin ev_lost = 1; m_state = S_HUNT; end
                end else bad_run = 0;
            end
        end

        if (clr) begin e_err = 0; e_had = 0; e_lost = 0; end
        else if (ev_err) begin
            if (e_err != ERR_SAT) e_err = e_err + 16'd1;
            e_had = 1;
            if (ev_lost) e_lost = 1;
        end
        if (m_state == S_HUNT) e_valid = 0;
        e_cew = (m_state != S_HUNT) ? (4'b0001 << m_pos) : 4'b0000;
    endtask

    task automatic compare_all();
        check("cew",          fib.cew,          e_cew);
        check("rcv_data",     fib.rcv_data,     e_rcv);
        check("rcv_kchar",    fib.rcv_kchar,    e_kchar);
        check("prompt_data",  fib.prompt_data,  e_prompt);
        check("nonzero_word", fib.nonzero_word, e_nz);
        check("ltncy_trig",   fib.ltncy_trig,   e_trig);
        check("valid",        fib.valid,        e_valid);
        check("link_good",    fib.link_good,    m_state == S_LOCKED);
        check("link_bad",     fib.link_bad,     e_lost);
        check("link_had_err", fib.link_had_err, e_had);
        check("errcount",     fib.errcount,     e_err);
    endtask

    task automatic drive_word(input logic [15:0] d, input logic [1:0] ck, de, nt,
                              input bit fe, clr, sync);
        fib.rx_data = d; fib.rx_charisk = ck; fib.rx_disperr = de; fib.rx_notintable = nt;
        fib.force_error = fe; fib.err_clr = clr; fib.rx_sync_done = sync;
        @(posedge rx_clk160);
        if (!gtx_rx_reset) model_edge(d, ck, de, nt, fe, clr, sync);
        #1;
        compare_all();
    endtask

    function automatic frame_t clean_frame(input logic [15:0] w0, w1, w2, w3);
        frame_t f;
        f.w = {w3, w2, w1, w0};
        f.k0 = 1; f.bad_at = -1; f.fe_at = -1; f.clr_at = -1; f.nosync_at = -1; f.kc_at = -1;
        f.bad_nt = 0;
        return f;
    endfunction

    task automatic send_frame(input frame_t f);
        logic [15:0] d;
        logic [1:0]  ck, de, nt;
        for (int k = 0; k < 4; k++) begin
            d  = f.w[k];
            ck = (k == 0 && f.k0) ? 2'b01 : 2'b00;
            if (k == f.kc_at) begin ck = 2'b01; d[7:0] = 8'hBC; end
            de = (k == f.bad_at && !f.bad_nt) ? 2'b01 : 2'b00;
            nt = (k == f.bad_at &&  f.bad_nt) ? 2'b10 : 2'b00;
            drive_word(d, ck, de, nt, k == f.fe_at, k == f.clr_at, k != f.nosync_at);
        end
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send_frame(clean_frame(16'h50BC, 16'h1, 16'h2, 16'h3));
    endtask

    function automatic logic [15:0] rnd_word();
        return ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    endfunction

    frame_t f;

    initial begin
        gtx_rx_reset = 1'b1;
        fib.rx_data = 0; fib.rx_charisk = 0; fib.rx_disperr = 0; fib.rx_notintable = 0;
        fib.force_error = 0; fib.err_clr = 0; fib.rx_sync_done = 1;
        model_reset();
        repeat (3) @(posedge rx_clk160);
        #1;
        compare_all();
        check("reset_cew", fib.cew, 4'b0000);
        gtx_rx_reset = 1'b0;

        // 1: lock on 8 clean frames
        send_clean(LOCK_FRAMES);
        check("t1_link_good", fib.link_good, 1'b1);
        check("t1_rcv_data",  fib.rcv_data,  48'h000300020001);
        check("t1_rcv_kchar", fib.rcv_kchar, 16'h50BC);
        check("t1_nonzero",   fib.nonzero_word, 3'b111);
        check("t1_cew3",      fib.cew, 4'b1000);
        send_clean(1);

        // 2: disparity error on word2
        f = clean_frame(16'h50BC, 16'h1, 16'h2, 16'h3);
        f.bad_at = 2;
        send_frame(f);
        check("t2_errcount",  fib.errcount, 16'd1);
        check("t2_had_err",   fib.link_had_err, 1'b1);
        check("t2_valid",     fib.valid, 1'b0);
        check("t2_link_good", fib.link_good, 1'b1);
        send_clean(1);
        check("t2_valid_back", fib.valid, 1'b1);

        // 3: four frames without comma -> lock lost, relock, then clear
        for (int i = 0; i < UNLOCK; i++) begin
            f = clean_frame(16'h50BC, 16'h7, 16'h8, 16'h9);
            f.k0 = 0;
            send_frame(f);
        end
        check("t3_link_good", fib.link_good, 1'b0);
        check("t3_link_bad",  fib.link_bad, 1'b1);
        send_clean(LOCK_FRAMES);
        check("t3_relock",    fib.link_good, 1'b1);
        check("t3_bad_sticky", fib.link_bad, 1'b1);
        f = clean_frame(16'h50BC, 16'h1, 16'h0, 16'h3);
        f.clr_at = 1;
        send_frame(f);
        check("t3_bad_cleared", fib.link_bad, 1'b0);
        check("t3_nonzero",     fib.nonzero_word, 3'b101);

        // 4: latency trigger frame
        send_frame(clean_frame(16'h50FC, 16'hA, 16'hB, 16'hC));
        check("t4_trig", fib.ltncy_trig, 1'b1);
        check("t4_cew3", fib.cew, 4'b1000);
        drive_word(16'h50BC, 2'b01, 2'b00, 2'b00, 0, 0, 1);
        check("t4_trig_gone", fib.ltncy_trig, 1'b0);
        for (int k = 1; k < 4; k++) drive_word(16'(k), 2'b00, 2'b00, 2'b00, 0, 0, 1);

        // 5: saturation, then clear coinciding with a bad frame
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 3; b++) begin
                f = clean_frame(16'h50BC, 16'h1, 16'h2, 16'h3);
                f.fe_at = 1;
                send_frame(f);
            end
            send_clean(1);
        end
        check("t5_sat", fib.errcount, ERR_SAT);
        f = clean_frame(16'h50BC, 16'h1, 16'h2, 16'h3);
        f.fe_at = 2;
        send_frame(f);
        check("t5_sat_hold", fib.errcount, ERR_SAT);
        f = clean_frame(16'h50BC, 16'h1, 16'h2, 16'h3);
        f.fe_at = 0; f.clr_at = 3;
        send_frame(f);
        check("t5_clr_wins", fib.errcount, 16'd0);
        check("t5_had_clr",  fib.link_had_err, 1'b0);

        // sync loss: drop to HUNT, status held
        f = clean_frame(16'h50BC, 16'h1, 16'h2, 16'h3);
        f.nosync_at = 1;
        send_frame(f);
        check("sync_link_good", fib.link_good, 1'b0);
        send_clean(LOCK_FRAMES + 1);

        // 6: asynchronous reset mid-frame, then a stream misaligned by two words
        drive_word(16'h50BC, 2'b01, 2'b00, 2'b00, 0, 0, 1);
        drive_word(16'h1111, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        #2;
        gtx_rx_reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("t6_rst_rcv", fib.rcv_data, 48'h0);
        repeat (2) @(posedge rx_clk160);
        #1;
        gtx_rx_reset = 1'b0;
        drive_word(16'h1234, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        drive_word(16'h5678, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        drive_word(16'h50BC, 2'b01, 2'b00, 2'b00, 0, 0, 1);
        check("t6_cew0", fib.cew, 4'b0001);
        for (int k = 1; k < 4; k++) drive_word(16'(k), 2'b00, 2'b00, 2'b00, 0, 0, 1);
        send_clean(LOCK_FRAMES - 1);
        check("t6_relock", fib.link_good, 1'b1);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 49) == 0)
                repeat ($urandom_range(1, 3))
                    drive_word(16'($urandom), 2'b00, 2'b00, 2'b00, 0, 0, 1);
            f = clean_frame({8'($urandom), ($urandom_range(0, 7) == 0) ? 8'hFC : 8'hBC},
                            rnd_word(), rnd_word(), rnd_word());
            if ($urandom_range(0, 19) == 0) f.k0 = 0;
            if ($urandom_range(0, 11) == 0) f.bad_at = $urandom_range(0, 3);
            f.bad_nt = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) f.fe_at = $urandom_range(0, 3);
            if ($urandom_range(0, 29) == 0) f.clr_at = $urandom_range(0, 3);
            if ($urandom_range(0, 99) == 0) f.nosync_at = $urandom_range(0, 3);
            if ($urandom_range(0, 39) == 0) f.kc_at = $urandom_range(1, 3);
            send_frame(f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
